// File: rtl/block_ram_pkg.sv
// Shared types and helpers for the multi-word block RAM controller.
package block_ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_t;

  localparam logic [7:0] DEFAULT_INIT_WORD = 8'hFF;

  localparam int LANE_MAX_W = 64;
  localparam int BUS_MAX_W  = 1024;

  // Extracts lane idx of a packed multi-lane word; data is zero-extended by the caller.
  function automatic logic [LANE_MAX_W-1:0] lane_slice(input logic [BUS_MAX_W-1:0] data,
                                                       input int idx, input int width);
    logic [BUS_MAX_W-1:0]  shifted;
    logic [LANE_MAX_W-1:0] mask;
    shifted = data >> (idx * width);
    mask = (width >= LANE_MAX_W) ? '1 : ((LANE_MAX_W'(1) << width) - LANE_MAX_W'(1));
    return shifted[LANE_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/block_ram_multi_word_ctl_if.sv
// Bus bundle between a client and block_ram_multi_word_ctl.
interface block_ram_multi_word_ctl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int NUM_WORDS  = 9
);
  import block_ram_pkg::*;

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: rd_en is a request with no backpressure; it is accepted whenever
  // init_busy is low, and each accepted request yields exactly one rd_valid pulse.
  logic                            init_req;
  logic                            init_busy;
  logic [DATA_WIDTH-1:0]           wr_data;
  logic [ADDR_W-1:0]               wr_addr;
  logic [NUM_WORDS-1:0]            wr_en;
  logic                            rd_en;
  logic [ADDR_W-1:0]               rd_addr;
  logic [DATA_WIDTH*NUM_WORDS-1:0] rd_data;
  logic                            rd_valid;
  ram_state_t                      dbg_state;

  modport master (
    output init_req, wr_data, wr_addr, wr_en, rd_en, rd_addr,
    input  init_busy, rd_data, rd_valid, dbg_state
  );

  modport slave (
    input  init_req, wr_data, wr_addr, wr_en, rd_en, rd_addr,
    output init_busy, rd_data, rd_valid, dbg_state
  );

endinterface

// File: rtl/block_ram_lane.sv
// One lane: simple dual-port RAM, registered read, read-first on collision.
module block_ram_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/block_ram_multi_word_ctl.sv
// Multi-lane scratch RAM with clear sequencer, bypass, range guard and read pipeline.
module block_ram_multi_word_ctl
  import block_ram_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int DEPTH           = 4,
  parameter int NUM_WORDS       = 9,
  parameter int OUTPUT_REGISTER = 0,
  parameter int RD_BYPASS       = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_WORD = DATA_WIDTH'(DEFAULT_INIT_WORD)
) (
  input logic clk,
  input logic rst,
  block_ram_multi_word_ctl_if.slave bus
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BUS_W  = DATA_WIDTH * NUM_WORDS;

  ram_state_t        state;
  logic [ADDR_W-1:0] clr_addr;
  logic              init_busy_q;

  logic clearing, wr_in_range, rd_in_range, rd_acc, collide;
  assign clearing    = (state == CLEAR);
  assign wr_in_range = int'(bus.wr_addr) < DEPTH;
  assign rd_in_range = int'(bus.rd_addr) < DEPTH;
  assign rd_acc      = bus.rd_en && !clearing;
  assign collide     = (RD_BYPASS != 0) && rd_acc && wr_in_range && rd_in_range &&
                       (bus.rd_addr == bus.wr_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLEAR;
      clr_addr    <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            state       <= RUN;
            clr_addr    <= '0;
            init_busy_q <= 1'b0;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        RUN: begin
          if (bus.init_req) begin
            state       <= CLEAR;
            clr_addr    <= '0;
            init_busy_q <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign bus.init_busy = init_busy_q;
  assign bus.dbg_state = state;

  // The sequencer owns every lane's write port while clearing.
  logic [NUM_WORDS-1:0]  lane_we;
  logic [ADDR_W-1:0]     lane_waddr, lane_raddr;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [BUS_W-1:0]      lane_rdata;

  always_comb begin
    lane_we    = '0;
    lane_waddr = bus.wr_addr;
    lane_wdata = bus.wr_data;
    if (clearing) begin
      lane_we    = '1;
      lane_waddr = clr_addr;
      lane_wdata = INIT_WORD;
    end else if (wr_in_range) begin
      lane_we = bus.wr_en;
    end
  end

  assign lane_raddr = rd_in_range ? bus.rd_addr : '0;

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_lane
    block_ram_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
    ) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .waddr (lane_waddr),
      .wdata (lane_wdata),
      .re    (rd_acc),
      .raddr (lane_raddr),
      .rdata (lane_rdata[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Stage-1 side info travels with the lane read; it only updates on an accepted
  // read so the merged word holds between reads.
  logic                  s1_valid, s1_have, s1_oob;
  logic [NUM_WORDS-1:0]  s1_bmask;
  logic [DATA_WIDTH-1:0] s1_bdata;
  logic [BUS_W-1:0]      s1_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_have  <= 1'b0;
      s1_oob   <= 1'b0;
      s1_bmask <= '0;
      s1_bdata <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) begin
        s1_have  <= 1'b1;
        s1_oob   <= !rd_in_range;
        s1_bmask <= collide ? bus.wr_en : '0;
        s1_bdata <= bus.wr_data;
      end
    end
  end

  always_comb begin
    s1_data = '0;
    if (s1_have && !s1_oob) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        s1_data[i*DATA_WIDTH +: DATA_WIDTH] = s1_bmask[i] ? s1_bdata
                                             : lane_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  if (OUTPUT_REGISTER != 0) begin : g_out_reg
    logic [BUS_W-1:0] out_data;
    logic             out_valid;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_data  <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= s1_valid;
        if (s1_valid) out_data <= s1_data;
      end
    end
    assign bus.rd_data  = out_data;
    assign bus.rd_valid = out_valid;
  end else begin : g_out_comb
    assign bus.rd_data  = s1_data;
    assign bus.rd_valid = s1_valid;
  end

endmodule

// File: tb/tb_block_ram_multi_word_ctl.sv
// Directed bench: default build, read-first build, and a registered-output DEPTH=5 build.
module tb_block_ram_multi_word_ctl;
  import block_ram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  block_ram_multi_word_ctl_if                 if_a ();
  block_ram_multi_word_ctl_if                 if_b ();
  block_ram_multi_word_ctl_if #(.DEPTH(5))    if_c ();

  block_ram_multi_word_ctl                              dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  block_ram_multi_word_ctl #(.RD_BYPASS(0))             dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  block_ram_multi_word_ctl #(.DEPTH(5), .OUTPUT_REGISTER(1)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if_a.init_req = 0; if_a.wr_data = '0; if_a.wr_addr = '0; if_a.wr_en = '0; if_a.rd_en = 0; if_a.rd_addr = '0;
    if_b.init_req = 0; if_b.wr_data = '0; if_b.wr_addr = '0; if_b.wr_en = '0; if_b.rd_en = 0; if_b.rd_addr = '0;
    if_c.init_req = 0; if_c.wr_data = '0; if_c.wr_addr = '0; if_c.wr_en = '0; if_c.rd_en = 0; if_c.rd_addr = '0;
  endtask

  task automatic write_a(input logic [1:0] addr, input logic [7:0] data, input logic [8:0] en);
    if_a.wr_addr = addr; if_a.wr_data = data; if_a.wr_en = en;
    tick();
    if_a.wr_en = '0;
  endtask

  task automatic write_c(input logic [2:0] addr, input logic [7:0] data, input logic [8:0] en);
    if_c.wr_addr = addr; if_c.wr_data = data; if_c.wr_en = en;
    tick();
    if_c.wr_en = '0;
  endtask

  task automatic read_a(input logic [1:0] addr, input logic [71:0] exp, input string nm);
    if_a.rd_en = 1; if_a.rd_addr = addr;
    tick();
    if_a.rd_en = 0;
    @(negedge clk);
    vec_cnt++;
    if (if_a.rd_valid !== 1'b1 || if_a.rd_data !== exp) begin
      err_cnt++;
      $display("FAIL %s: got valid=%b data=%h, required valid=1 data=%h", nm, if_a.rd_valid, if_a.rd_data, exp);
    end
    tick();
  endtask

  task automatic read_b(input logic [1:0] addr, input logic [71:0] exp, input string nm);
    if_b.rd_en = 1; if_b.rd_addr = addr;
    tick();
    if_b.rd_en = 0;
    @(negedge clk);
    vec_cnt++;
    if (if_b.rd_valid !== 1'b1 || if_b.rd_data !== exp) begin
      err_cnt++;
      $display("FAIL %s: got valid=%b data=%h, required valid=1 data=%h", nm, if_b.rd_valid, if_b.rd_data, exp);
    end
    tick();
  endtask

  task automatic read_c(input logic [2:0] addr, input logic [71:0] exp, input string nm);
    if_c.rd_en = 1; if_c.rd_addr = addr;
    tick();
    if_c.rd_en = 0;
    @(negedge clk);
    vec_cnt++;
    if (if_c.rd_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_early: got valid=%b one cycle after request, required 0", nm, if_c.rd_valid);
    end
    tick();
    @(negedge clk);
    vec_cnt++;
    if (if_c.rd_valid !== 1'b1 || if_c.rd_data !== exp) begin
      err_cnt++;
      $display("FAIL %s: got valid=%b data=%h, required valid=1 data=%h", nm, if_c.rd_valid, if_c.rd_data, exp);
    end
    tick();
  endtask

  task automatic test_reset();
    int cnt_a, cnt_b, cnt_c;
    bit da, db, dc;
    idle_all();
    tick();
    tick();
    @(negedge clk);
    vec_cnt++;
    if (if_a.rd_data !== '0 || if_a.rd_valid !== 1'b0 || if_a.init_busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_a: got data=%h valid=%b busy=%b, required 0/0/1", if_a.rd_data, if_a.rd_valid, if_a.init_busy);
    end
    vec_cnt++;
    if (if_c.rd_data !== '0 || if_c.rd_valid !== 1'b0 || if_c.init_busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_c: got data=%h valid=%b busy=%b, required 0/0/1", if_c.rd_data, if_c.rd_valid, if_c.init_busy);
    end
    tick();
    rst = 0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0; da = 0; db = 0; dc = 0;
    for (int i = 0; i < 20 && !(da && db && dc); i++) begin
      @(negedge clk);
      if (!da) begin if (if_a.init_busy) cnt_a++; else da = 1; end
      if (!db) begin if (if_b.init_busy) cnt_b++; else db = 1; end
      if (!dc) begin if (if_c.init_busy) cnt_c++; else dc = 1; end
      tick();
    end
    vec_cnt++;
    if (cnt_a != 4) begin err_cnt++; $display("FAIL init_busy_len_a: got %0d cycles, required 4", cnt_a); end
    vec_cnt++;
    if (cnt_b != 4) begin err_cnt++; $display("FAIL init_busy_len_b: got %0d cycles, required 4", cnt_b); end
    vec_cnt++;
    if (cnt_c != 5) begin err_cnt++; $display("FAIL init_busy_len_c: got %0d cycles, required 5", cnt_c); end
  endtask

  task automatic test_init_read();
    for (int k = 0; k < 4; k++) read_a(2'(k), {9{8'hFF}}, "init_read_a");
    read_b(2'd2, {9{8'hFF}}, "init_read_b");
  endtask

  task automatic test_lane_mask();
    logic [BUS_MAX_W-1:0]  wide;
    logic [LANE_MAX_W-1:0] lane;
    logic [7:0]            exp_lane;
    write_a(2'd2, 8'hA5, 9'b000000101);
    read_a(2'd2, {{6{8'hFF}}, 8'hA5, 8'hFF, 8'hA5}, "lane_mask");
    @(negedge clk);
    vec_cnt++;
    if (if_a.rd_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL valid_pulse: got valid=%b while idle, required 0", if_a.rd_valid);
    end
    wide = '0;
    wide[71:0] = if_a.rd_data;
    for (int i = 0; i < 9; i++) begin
      lane = lane_slice(wide, i, 8);
      exp_lane = (i == 0 || i == 2) ? 8'hA5 : 8'hFF;
      vec_cnt++;
      if (lane[7:0] !== exp_lane) begin
        err_cnt++;
        $display("FAIL hold_lane%0d: got %h, required %h", i, lane[7:0], exp_lane);
      end
    end
    tick();
  endtask

  task automatic test_collision();
    if_a.wr_addr = 2'd1; if_a.wr_data = 8'h3C; if_a.wr_en = 9'h1FF; if_a.rd_en = 1; if_a.rd_addr = 2'd1;
    if_b.wr_addr = 2'd1; if_b.wr_data = 8'h3C; if_b.wr_en = 9'h1FF; if_b.rd_en = 1; if_b.rd_addr = 2'd1;
    tick();
    if_a.wr_en = '0; if_a.rd_en = 0; if_b.wr_en = '0; if_b.rd_en = 0;
    @(negedge clk);
    vec_cnt++;
    if (if_a.rd_valid !== 1'b1 || if_a.rd_data !== {9{8'h3C}}) begin
      err_cnt++;
      $display("FAIL collide_bypass: got valid=%b data=%h, required valid=1 data=%h", if_a.rd_valid, if_a.rd_data, {9{8'h3C}});
    end
    vec_cnt++;
    if (if_b.rd_valid !== 1'b1 || if_b.rd_data !== {9{8'hFF}}) begin
      err_cnt++;
      $display("FAIL collide_read_first: got valid=%b data=%h, required valid=1 data=%h", if_b.rd_valid, if_b.rd_data, {9{8'hFF}});
    end
    tick();
    read_b(2'd1, {9{8'h3C}}, "after_collide_b");
    if_a.wr_addr = 2'd0; if_a.wr_data = 8'h77; if_a.wr_en = 9'h003; if_a.rd_en = 1; if_a.rd_addr = 2'd0;
    tick();
    if_a.wr_en = '0; if_a.rd_en = 0;
    @(negedge clk);
    vec_cnt++;
    if (if_a.rd_valid !== 1'b1 || if_a.rd_data !== {{7{8'hFF}}, 8'h77, 8'h77}) begin
      err_cnt++;
      $display("FAIL collide_partial: got valid=%b data=%h, required valid=1 data=%h", if_a.rd_valid, if_a.rd_data, {{7{8'hFF}}, 8'h77, 8'h77});
    end
    tick();
    read_a(2'd0, {{7{8'hFF}}, 8'h77, 8'h77}, "after_partial_a");
  endtask

  task automatic test_latency_range();
    for (int k = 0; k < 5; k++) write_c(3'(k), 8'(16 + k), 9'h1FF);
    for (int i = 0; i < 8; i++) begin
      if (i < 5) begin if_c.rd_en = 1; if_c.rd_addr = 3'(i); end
      else if_c.rd_en = 0;
      @(negedge clk);
      vec_cnt++;
      if (i >= 2 && i < 7) begin
        if (if_c.rd_valid !== 1'b1 || if_c.rd_data !== {9{8'(16 + i - 2)}}) begin
          err_cnt++;
          $display("FAIL b2b_read%0d: got valid=%b data=%h, required valid=1 data=%h", i - 2, if_c.rd_valid, if_c.rd_data, {9{8'(16 + i - 2)}});
        end
      end else if (if_c.rd_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL b2b_idle%0d: got valid=%b, required 0", i, if_c.rd_valid);
      end
      tick();
    end
    write_c(3'd6, 8'h5A, 9'h1FF);
    read_c(3'd6, 72'h0, "oob_read");
    read_c(3'd2, {9{8'h12}}, "oob_no_change2");
    read_c(3'd4, {9{8'h14}}, "oob_no_change4");
  endtask

  task automatic test_reinit();
    int cnt;
    write_a(2'd3, 8'h11, 9'h1FF);
    if_a.init_req = 1; if_a.rd_en = 1; if_a.rd_addr = 2'd3;
    tick();
    if_a.init_req = 0; if_a.rd_addr = 2'd0;
    @(negedge clk);
    vec_cnt++;
    if (if_a.rd_valid !== 1'b1 || if_a.rd_data !== {9{8'h11}} || if_a.init_busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL reinit_inflight: got valid=%b data=%h busy=%b, required 1/%h/1", if_a.rd_valid, if_a.rd_data, if_a.init_busy, {9{8'h11}});
    end
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if_a.rd_en = 0;
      @(negedge clk);
      vec_cnt++;
      if (if_a.rd_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL busy_read: got valid=%b during clear, required 0", if_a.rd_valid);
      end
      if (if_a.init_busy) cnt++;
      else break;
    end
    tick();
    vec_cnt++;
    if (cnt != 4) begin err_cnt++; $display("FAIL reinit_busy_len: got %0d cycles, required 4", cnt); end
    read_a(2'd3, {9{8'hFF}}, "reinit_addr3");
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    write_a(2'd0, 8'h44, 9'h1FF);
    write_a(2'd3, 8'h44, 9'h1FF);
    read_a(2'd3, {9{8'h44}}, "pre_reset_read");
    if_a.init_req = 1;
    tick();
    if_a.init_req = 0;
    tick();
    #1 rst = 1;
    #1;
    vec_cnt++;
    if (if_a.rd_data !== '0 || if_a.rd_valid !== 1'b0 || if_a.init_busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL mid_clear_reset: got data=%h valid=%b busy=%b, required 0/0/1", if_a.rd_data, if_a.rd_valid, if_a.init_busy);
    end
    tick();
    rst = 0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_a.init_busy) cnt++;
      else break;
      tick();
    end
    tick();
    vec_cnt++;
    if (cnt != 4) begin err_cnt++; $display("FAIL restart_busy_len: got %0d cycles, required 4", cnt); end
    read_a(2'd3, {9{8'hFF}}, "restart_addr3");
    read_a(2'd0, {9{8'hFF}}, "restart_addr0");
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_lane_mask();
    test_collision();
    test_latency_range();
    test_reinit();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
